// File: rtl/execute_cc.sv
// Execute-stage back end: condition-code register, jXX/cmovXX condition evaluation and E->M pipeline register.
// Optional feature macro CC_EXC_SUPPRESS_EN blocks CC writes while m_exc or w_exc is high.
module execute_cc #(
  parameter logic [3:0] RNONE      = 4'hF,
  parameter logic [3:0] ICODE_CMOV = 4'h2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        e_valid,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_ifun,
  input  logic        e_set_cc,
  input  logic [63:0] alu_out,
  input  logic        alu_of,
  input  logic [3:0]  e_dstE,
  input  logic        m_exc,
  input  logic        w_exc,
  input  logic        stall_m,
  input  logic        bubble_m,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of,
  output logic        e_cnd,
  output logic [3:0]  e_dstE_eff,
  output logic        M_valid,
  output logic [63:0] M_valE,
  output logic        M_cnd,
  output logic [3:0]  M_dstE
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned RW   = 4;

  logic            r_zf;
  logic            r_sf;
  logic            r_of;
  logic            r_m_valid;
  logic [XLEN-1:0] r_m_vale;
  logic            r_m_cnd;
  logic [RW-1:0]   r_m_dste;

  logic            w_zf;
  logic            w_sf;
  logic            w_cc_we;
  logic            w_cnd;
  logic            w_lt;
  logic [RW-1:0]   w_dste_eff;

  assign w_zf = (alu_out == XLEN'(0));
  assign w_sf = alu_out[XLEN-1];

`ifdef CC_EXC_SUPPRESS_EN
  // A younger instruction must not change flags behind a faulting one.
  assign w_cc_we = e_valid & e_set_cc & ~stall_m & ~m_exc & ~w_exc;
`else
  logic w_unused_exc;
  assign w_unused_exc = m_exc | w_exc;
  assign w_cc_we      = e_valid & e_set_cc & ~stall_m;
`endif

  // Condition evaluation uses only the stored flags.
  assign w_lt = r_sf ^ r_of;

  always_comb begin
    w_cnd = 1'b0;
    case (e_ifun)
      4'd0:    w_cnd = 1'b1;
      4'd1:    w_cnd = w_lt | r_zf;
      4'd2:    w_cnd = w_lt;
      4'd3:    w_cnd = r_zf;
      4'd4:    w_cnd = ~r_zf;
      4'd5:    w_cnd = ~w_lt;
      4'd6:    w_cnd = ~w_lt & ~r_zf;
      default: w_cnd = 1'b0;
    endcase
  end

  assign w_dste_eff = ((e_icode == ICODE_CMOV) && !w_cnd) ? RNONE : e_dstE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zf <= 1'b1;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_cc_we) begin
      r_zf <= w_zf;
      r_sf <= w_sf;
      r_of <= alu_of;
    end
  end

  // E->M register: stall holds, bubble inserts a NOP, otherwise load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_vale  <= '0;
      r_m_cnd   <= 1'b0;
      r_m_dste  <= RNONE;
    end else if (!stall_m) begin
      if (bubble_m) begin
        r_m_valid <= 1'b0;
        r_m_vale  <= '0;
        r_m_cnd   <= 1'b0;
        r_m_dste  <= RNONE;
      end else begin
        r_m_valid <= e_valid;
        r_m_vale  <= alu_out;
        r_m_cnd   <= w_cnd;
        r_m_dste  <= w_dste_eff;
      end
    end
  end

  assign cc_zf      = r_zf;
  assign cc_sf      = r_sf;
  assign cc_of      = r_of;
  assign e_cnd      = w_cnd;
  assign e_dstE_eff = w_dste_eff;
  assign M_valid    = r_m_valid;
  assign M_valE     = r_m_vale;
  assign M_cnd      = r_m_cnd;
  assign M_dstE     = r_m_dste;

endmodule

// File: tb/tb_execute_cc.sv
// Directed self-checking bench for execute_cc; exception expectations follow CC_EXC_SUPPRESS_EN.
module tb_execute_cc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        e_valid = 1'b0;
  logic [3:0]  e_icode = 4'h0;
  logic [3:0]  e_ifun = 4'h0;
  logic        e_set_cc = 1'b0;
  logic [63:0] alu_out = 64'h0;
  logic        alu_of = 1'b0;
  logic [3:0]  e_dstE = 4'hF;
  logic        m_exc = 1'b0;
  logic        w_exc = 1'b0;
  logic        stall_m = 1'b0;
  logic        bubble_m = 1'b0;
  logic        cc_zf, cc_sf, cc_of, e_cnd, M_valid, M_cnd;
  logic [3:0]  e_dstE_eff, M_dstE;
  logic [63:0] M_valE;

  int n_cmp  = 0;
  int n_fail = 0;

  execute_cc dut (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_set_cc(e_set_cc), .alu_out(alu_out), .alu_of(alu_of), .e_dstE(e_dstE),
    .m_exc(m_exc), .w_exc(w_exc), .stall_m(stall_m), .bubble_m(bubble_m),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .e_cnd(e_cnd), .e_dstE_eff(e_dstE_eff),
    .M_valid(M_valid), .M_valE(M_valE), .M_cnd(M_cnd), .M_dstE(M_dstE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Async reset before any clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_zf", 64'(cc_zf), 64'd1);
    check("rst_sf", 64'(cc_sf), 64'd0);
    check("rst_of", 64'(cc_of), 64'd0);
    check("rst_mvalid", 64'(M_valid), 64'd0);
    check("rst_mvale", M_valE, 64'd0);
    check("rst_mdste", 64'(M_dstE), 64'hF);
    check("rst_mcnd", 64'(M_cnd), 64'd0);
    tick();
    rst = 1'b0;

    // OPq positive result clears ZF
    e_valid = 1'b1; e_icode = 4'h6; e_ifun = 4'h0; e_set_cc = 1'b1;
    alu_out = 64'd5; alu_of = 1'b0; e_dstE = 4'h2;
    tick();
    check("op5_zf", 64'(cc_zf), 64'd0);
    check("op5_mvalid", 64'(M_valid), 64'd1);
    check("op5_mvale", M_valE, 64'd5);
    check("op5_mdste", 64'(M_dstE), 64'h2);

    // OPq zero result, then je
    alu_out = 64'd0;
    tick();
    check("op0_zf", 64'(cc_zf), 64'd1);
    check("op0_sf", 64'(cc_sf), 64'd0);
    e_icode = 4'h7; e_ifun = 4'h3; e_set_cc = 1'b0; alu_out = 64'hAA; e_dstE = 4'hF;
    #1;
    check("je_cnd", 64'(e_cnd), 64'd1);
    tick();
    check("je_mcnd", 64'(M_cnd), 64'd1);
    check("je_zf_kept", 64'(cc_zf), 64'd1);

    // Same-cycle flags must not affect e_cnd
    e_icode = 4'h6; e_ifun = 4'h3; e_set_cc = 1'b1; alu_out = 64'd7;
    #1;
    check("stored_flags_cnd", 64'(e_cnd), 64'd1);
    tick();
    check("after_op7_cnd", 64'(e_cnd), 64'd0);

    // Signed overflow compare
    alu_out = 64'h8000_0000_0000_0000; alu_of = 1'b1;
    tick();
    check("ovf_sf", 64'(cc_sf), 64'd1);
    check("ovf_of", 64'(cc_of), 64'd1);
    check("ovf_zf", 64'(cc_zf), 64'd0);
    e_set_cc = 1'b0; e_icode = 4'h7;
    e_ifun = 4'h2; #1; check("cnd_l", 64'(e_cnd), 64'd0);
    e_ifun = 4'h5; #1; check("cnd_ge", 64'(e_cnd), 64'd1);
    e_ifun = 4'h1; #1; check("cnd_le", 64'(e_cnd), 64'd0);
    e_ifun = 4'h6; #1; check("cnd_g", 64'(e_cnd), 64'd1);
    e_ifun = 4'h4; #1; check("cnd_ne", 64'(e_cnd), 64'd1);
    e_ifun = 4'h0; #1; check("cnd_always", 64'(e_cnd), 64'd1);
    e_ifun = 4'h9; #1; check("cnd_undef", 64'(e_cnd), 64'd0);

    // Not-taken cmov suppresses destination
    e_icode = 4'h2; e_ifun = 4'h3; e_dstE = 4'h3;
    #1;
    check("cmov_nt_eff", 64'(e_dstE_eff), 64'hF);
    tick();
    check("cmov_nt_mdste", 64'(M_dstE), 64'hF);
    check("cmov_nt_mcnd", 64'(M_cnd), 64'd0);
    e_ifun = 4'h0;
    #1;
    check("rrmov_eff", 64'(e_dstE_eff), 64'h3);
    tick();
    check("rrmov_mdste", 64'(M_dstE), 64'h3);

    // Stall beats bubble; CC not written during stall
    e_icode = 4'h6; e_ifun = 4'h0; e_dstE = 4'h5; alu_out = 64'h1234; alu_of = 1'b0;
    tick();
    check("load_1234", M_valE, 64'h1234);
    stall_m = 1'b1; bubble_m = 1'b1; e_set_cc = 1'b1; alu_out = 64'h5678;
    tick();
    check("stall_mvale", M_valE, 64'h1234);
    check("stall_mvalid", 64'(M_valid), 64'd1);
    check("stall_sf", 64'(cc_sf), 64'd1);
    check("stall_of", 64'(cc_of), 64'd1);
    stall_m = 1'b0; e_set_cc = 1'b0;
    tick();
    check("bubble_mvalid", 64'(M_valid), 64'd0);
    check("bubble_mdste", 64'(M_dstE), 64'hF);
    check("bubble_mvale", M_valE, 64'd0);
    check("bubble_mcnd", 64'(M_cnd), 64'd0);

    // Invalid instruction: NOP entry, no CC write
    bubble_m = 1'b0; e_valid = 1'b0; e_set_cc = 1'b1; alu_out = 64'd0; e_dstE = 4'h6;
    tick();
    check("nop_mvalid", 64'(M_valid), 64'd0);
    check("nop_mdste", 64'(M_dstE), 64'h6);
    check("nop_zf", 64'(cc_zf), 64'd0);

    // Exception suppression
    e_valid = 1'b1; m_exc = 1'b1;
    tick();
`ifdef CC_EXC_SUPPRESS_EN
    check("mexc_zf", 64'(cc_zf), 64'd0);
    check("mexc_sf", 64'(cc_sf), 64'd1);
`else
    check("mexc_zf", 64'(cc_zf), 64'd1);
    check("mexc_sf", 64'(cc_sf), 64'd0);
`endif
    m_exc = 1'b0; w_exc = 1'b1; alu_out = 64'd0;
    tick();
`ifdef CC_EXC_SUPPRESS_EN
    check("wexc_zf", 64'(cc_zf), 64'd0);
`else
    check("wexc_zf", 64'(cc_zf), 64'd1);
`endif

    // Reset mid-stall discards in-flight contents
    w_exc = 1'b0; e_set_cc = 1'b0; alu_out = 64'd99; e_dstE = 4'h1;
    tick();
    check("pre_rst_mvale", M_valE, 64'd99);
    stall_m = 1'b1; alu_out = 64'd42;
    tick();
    check("pre_rst_hold", M_valE, 64'd99);
    #2 rst = 1'b1;
    #1;
    check("midrst_mvalid", 64'(M_valid), 64'd0);
    check("midrst_mvale", M_valE, 64'd0);
    check("midrst_mdste", 64'(M_dstE), 64'hF);
    check("midrst_zf", 64'(cc_zf), 64'd1);
    check("midrst_of", 64'(cc_of), 64'd0);
    tick();
    check("held_rst_mvale", M_valE, 64'd0);
    rst = 1'b0; stall_m = 1'b0;
    tick();
    check("post_rst_load", M_valE, 64'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
